// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW frame controller: FSM encoding, default
// framing geometry and the start-of-frame decision used by IDLE and CLR.
package lzw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        PLD,
        CLR,
        ERR
    } state_e;

    localparam int unsigned LZW_HDR_LEN     = 12;
    localparam int unsigned LZW_CRC_LEN     = 4;
    localparam int unsigned LZW_LOCK_FRAMES = 16;

    localparam logic [7:0] GMII_PREAMBLE = 8'h55;
    localparam logic [7:0] GMII_SFD      = 8'hD5;

    // CLR reuses this so a frame may start in the cycle right after the previous one.
    function automatic state_e idle_next(input logic dv, input logic [7:0] data);
        if (!dv) begin
            return IDLE;
        end
        return (data == GMII_PREAMBLE) ? PRE : ERR;
    endfunction

endpackage

// File: rtl/lzw_crc_strip.sv
// Payload delay line: holds the last DEPTH bytes back so trailing FCS bytes
// are never released; a byte pops out only when a newer byte pushes it.
module lzw_crc_strip
    import lzw_pkg::*;
#(
    parameter int unsigned DEPTH = LZW_CRC_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_vld
);

    logic [DEPTH-1:0][7:0] data_q, data_d;
    logic [DEPTH-1:0]      vld_q, vld_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (push) begin
            data_d[0] = din;
            vld_d[0]  = 1'b1;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end
    end

    always_comb begin
        dout     = data_q[DEPTH-1];
        dout_vld = push && !flush && vld_q[DEPTH-1];
    end

endmodule

// File: rtl/lzw_frame_ctrl.sv
// GMII frame front-end for the LZW compressor: strips preamble/SFD/header and FCS,
// counts good and aborted frames. Optional dictionary lock: define LZW_DICT_LOCK_EN.
module lzw_frame_ctrl
    import lzw_pkg::*;
#(
    parameter int unsigned HDR_LEN     = LZW_HDR_LEN,
    parameter int unsigned CRC_LEN     = LZW_CRC_LEN,
    parameter int unsigned LOCK_FRAMES = LZW_LOCK_FRAMES
) (
    input  logic        I_sys_clk,
    input  logic        I_sys_rst_n,
    input  logic [7:0]  I_gmii_data,
    input  logic        I_gmii_dv,
    output logic [7:0]  O_tx_data,
    output logic        O_tx_data_en,
    output logic        O_state_clr,
    output logic        O_dictionary_lock,
    input  logic        I_lock_clr,
    output logic [15:0] O_frame_cnt,
    output logic [15:0] O_err_cnt
);

    localparam int unsigned HCW = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;

    state_e         state_q, state_d;
    logic [HCW-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_en_q, tx_en_d;
    logic           out_seen_q, out_seen_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [15:0]    err_cnt_q, err_cnt_d;

    logic           push, flush, good_frame;
    logic [7:0]     pop_data;
    logic           pop_vld;

    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, CLR: state_d = idle_next(I_gmii_dv, I_gmii_data);
            PRE: begin
                if (!I_gmii_dv) begin
                    state_d = ERR;
                end else if (I_gmii_data == GMII_SFD) begin
                    state_d = HDR;
                end else if (I_gmii_data != GMII_PREAMBLE) begin
                    state_d = ERR;
                end
            end
            HDR: begin
                if (!I_gmii_dv) begin
                    state_d = ERR;
                end else if (hdr_cnt_q == HCW'(HDR_LEN - 1)) begin
                    state_d = PLD;
                end
            end
            PLD: if (!I_gmii_dv) state_d = CLR;
            ERR: if (!I_gmii_dv) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flushing in CLR/ERR covers every path back into IDLE, including CLR->PRE.
    always_comb begin
        push  = (state_q == PLD) && I_gmii_dv;
        flush = (state_q == CLR) || (state_q == ERR);
    end

    lzw_crc_strip #(
        .DEPTH (CRC_LEN)
    ) u_crc_strip (
        .clk      (I_sys_clk),
        .rst_n    (I_sys_rst_n),
        .push     (push),
        .flush    (flush),
        .din      (I_gmii_data),
        .dout     (pop_data),
        .dout_vld (pop_vld)
    );

    always_comb begin
        hdr_cnt_d = '0;
        if ((state_q == HDR) && I_gmii_dv) begin
            hdr_cnt_d = hdr_cnt_q + 1'b1;
        end
        tx_en_d     = pop_vld;
        tx_data_d   = pop_vld ? pop_data : tx_data_q;
        out_seen_d  = (state_q == PLD) && (out_seen_q || pop_vld);
        good_frame  = (state_q == CLR) && out_seen_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (good_frame) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else if ((state_q == CLR) || ((state_q == ERR) && !I_gmii_dv)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            hdr_cnt_q   <= '0;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            out_seen_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            hdr_cnt_q   <= hdr_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            out_seen_q  <= out_seen_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        O_tx_data    = tx_data_q;
        O_tx_data_en = tx_en_q;
        O_state_clr  = (state_q == CLR);
        O_frame_cnt  = frame_cnt_q;
        O_err_cnt    = err_cnt_q;
    end

`ifdef LZW_DICT_LOCK_EN
    localparam int unsigned LCW = $clog2(LOCK_FRAMES + 1);

    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           lock_q, lock_d;

    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    // Counter saturates so the lock edge happens once per release.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (good_frame) begin
            if (lock_cnt_q < LCW'(LOCK_FRAMES)) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
            if (lock_cnt_q == LCW'(LOCK_FRAMES - 1)) begin
                lock_d = 1'b1;
            end
        end
        if (I_lock_clr) begin
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end
    end

    always_comb O_dictionary_lock = lock_q;
`else
    logic unused_lock_clr;

    always_comb begin
        unused_lock_clr   = I_lock_clr;
        O_dictionary_lock = 1'b0;
    end
`endif

endmodule

// File: tb/tb_lzw_frame_ctrl.sv
// Directed bench for lzw_frame_ctrl: table of frame scenarios plus hand-written
// back-to-back, lock and reset-mid-frame sequences.
`timescale 1ns/1ps
module tb_lzw_frame_ctrl;

    localparam int CRC  = 4;
    localparam int HDRN = 12;
    localparam int LOCK = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  gmii_data;
    logic        gmii_dv;
    logic        lock_clr;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        state_clr;
    logic        dict_lock;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    lzw_frame_ctrl #(
        .HDR_LEN     (HDRN),
        .CRC_LEN     (CRC),
        .LOCK_FRAMES (LOCK)
    ) dut (
        .I_sys_clk         (clk),
        .I_sys_rst_n       (rst_n),
        .I_gmii_data       (gmii_data),
        .I_gmii_dv         (gmii_dv),
        .O_tx_data         (tx_data),
        .O_tx_data_en      (tx_en),
        .O_state_clr       (state_clr),
        .O_dictionary_lock (dict_lock),
        .I_lock_clr        (lock_clr),
        .O_frame_cnt       (frame_cnt),
        .O_err_cnt         (err_cnt)
    );

    typedef struct {
        int         n_pre;
        bit         has_sfd;
        logic [7:0] sfd;
        int         n_hdr;
        int         n_pld;
        int         exp_en;
        int         exp_clr;
        int         exp_good;
        int         exp_bad;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int drv_cyc = 0;
    int en_cnt  = 0;
    int clr_cnt = 0;
    int lock_target = -1;
    int target_cyc  = -1;
    int rise_cyc    = -1;
    int exp_frame = 0;
    int exp_err   = 0;
    logic [7:0] last_data = 8'h00;
    logic       lock_prev = 1'b0;
    logic [7:0] exp_dq[$];
    int         exp_cq[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input int i);
        case (i)
            0, 2:    return 8'h0A;
            1, 3:    return 8'h0B;
            4:       return 8'h0C;
            default: return 8'(8'h0D + i - 5);
        endcase
    endfunction

    function automatic logic [7:0] pld_byte(input int i, input int n);
        return (i >= n - CRC) ? 8'h04 : pay_byte(i);
    endfunction

    task automatic step(input logic dv, input logic [7:0] d);
        gmii_dv   = dv;
        gmii_data = d;
        @(posedge clk);
        #1;
        drv_cyc++;
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < v.n_pre; i++) step(1'b1, 8'h55);
        if (v.has_sfd) step(1'b1, v.sfd);
        for (int i = 0; i < v.n_hdr; i++) step(1'b1, (i < 6) ? 8'hDA : 8'h5A);
        for (int i = 0; i < v.n_pld; i++) begin
            if (i < v.exp_en) begin
                exp_dq.push_back(pay_byte(i));
                exp_cq.push_back(drv_cyc);
            end
            step(1'b1, pld_byte(i, v.n_pld));
        end
        step(1'b0, 8'h00);
    endtask

    // Output monitor: payload order/value/latency, hold behaviour, pulse counts.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = 8'h00;
            lock_prev = 1'b0;
        end else begin
            if (tx_en) begin
                en_cnt++;
                if (exp_dq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_en: got data 0x%0h at cycle %0d, required no enable", tx_data, drv_cyc);
                end else begin
                    check("tx_data", int'(tx_data), int'(exp_dq.pop_front()));
                    check("tx_latency", drv_cyc, exp_cq.pop_front() + CRC + 1);
                end
                last_data = tx_data;
            end else begin
                check("tx_hold", int'(tx_data), int'(last_data));
            end
            if (state_clr) begin
                clr_cnt++;
                if (clr_cnt == lock_target) target_cyc = drv_cyc;
            end
            if (dict_lock && !lock_prev) rise_cyc = drv_cyc;
            lock_prev = dict_lock;
        end
    end

    vec_t vecs[9];
    int   en0, clr0;

    initial begin
        vecs[0] = '{7, 1'b1, 8'hD5, HDRN, 24, 20, 1, 1, 0};
        vecs[1] = '{7, 1'b1, 8'hD4, HDRN, 24,  0, 0, 0, 1};
        vecs[2] = '{7, 1'b1, 8'hD5, HDRN,  3,  0, 1, 0, 1};
        vecs[3] = '{7, 1'b1, 8'hD5,    5,  0,  0, 0, 0, 1};
        vecs[4] = '{3, 1'b0, 8'h00,    0,  0,  0, 0, 0, 1};
        vecs[5] = '{0, 1'b1, 8'h12, HDRN, 24,  0, 0, 0, 1};
        vecs[6] = '{7, 1'b1, 8'hD5, HDRN,  5,  1, 1, 1, 0};
        vecs[7] = '{7, 1'b1, 8'hD5, HDRN,  4,  0, 1, 0, 1};
        vecs[8] = '{1, 1'b1, 8'hD5, HDRN, 24, 20, 1, 1, 0};

        rst_n     = 1'b0;
        gmii_dv   = 1'b0;
        gmii_data = 8'h00;
        lock_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_tx_en", int'(tx_en), 0);
        check("rst_state_clr", int'(state_clr), 0);
        check("rst_lock", int'(dict_lock), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        repeat (2) step(1'b0, 8'h00);

        for (int k = 0; k < 9; k++) begin
            en0  = en_cnt;
            clr0 = clr_cnt;
            send_frame(vecs[k]);
            repeat (3) step(1'b0, 8'h00);
            exp_frame += vecs[k].exp_good;
            exp_err   += vecs[k].exp_bad;
            check($sformatf("v%0d_en", k), en_cnt - en0, vecs[k].exp_en);
            check($sformatf("v%0d_clr", k), clr_cnt - clr0, vecs[k].exp_clr);
            check($sformatf("v%0d_frame_cnt", k), int'(frame_cnt), exp_frame);
            check($sformatf("v%0d_err_cnt", k), int'(err_cnt), exp_err);
            check($sformatf("v%0d_pending", k), exp_dq.size(), 0);
        end

        // Back-to-back frames with a single idle cycle; lock counter released first.
        lock_clr = 1'b1;
        step(1'b0, 8'h00);
        lock_clr = 1'b0;
        step(1'b0, 8'h00);
        check("lock_after_clr0", int'(dict_lock), 0);
        en0 = en_cnt;
        lock_target = clr_cnt + LOCK;
        for (int f = 0; f < 20; f++) send_frame(vecs[0]);
        repeat (3) step(1'b0, 8'h00);
        exp_frame += 20;
        check("b2b_en", en_cnt - en0, 400);
        check("b2b_frame_cnt", int'(frame_cnt), exp_frame);
        check("b2b_err_cnt", int'(err_cnt), exp_err);
        check("b2b_pending", exp_dq.size(), 0);
`ifdef LZW_DICT_LOCK_EN
        check("lock_rise_cycle", rise_cyc, target_cyc + 1);
        check("lock_held", int'(dict_lock), 1);
`else
        check("lock_never_rose", rise_cyc, -1);
        check("lock_off", int'(dict_lock), 0);
`endif
        lock_clr = 1'b1;
        step(1'b0, 8'h00);
        lock_clr = 1'b0;
        step(1'b0, 8'h00);
        check("lock_released", int'(dict_lock), 0);

        // Reset while payload byte 10 is on the wire; the rest of the frame lands in ERR.
        en0  = en_cnt;
        clr0 = clr_cnt;
        for (int i = 0; i < 7; i++) step(1'b1, 8'h55);
        step(1'b1, 8'hD5);
        for (int i = 0; i < HDRN; i++) step(1'b1, (i < 6) ? 8'hDA : 8'h5A);
        for (int i = 0; i < 24; i++) begin
            if (i < 5) begin
                exp_dq.push_back(pay_byte(i));
                exp_cq.push_back(drv_cyc);
            end
            if (i == 10) begin
                rst_n = 1'b0;
                #1;
                check("mid_rst_tx_data", int'(tx_data), 0);
                check("mid_rst_tx_en", int'(tx_en), 0);
                check("mid_rst_frame_cnt", int'(frame_cnt), 0);
                check("mid_rst_err_cnt", int'(err_cnt), 0);
                exp_frame = 0;
                exp_err   = 0;
            end
            if (i == 12) rst_n = 1'b1;
            step(1'b1, pld_byte(i, 24));
        end
        step(1'b0, 8'h00);
        repeat (3) step(1'b0, 8'h00);
        check("mid_rst_en", en_cnt - en0, 5);
        check("mid_rst_clr", clr_cnt - clr0, 0);
        check("mid_rst_err_after", int'(err_cnt), 1);
        check("mid_rst_frame_after", int'(frame_cnt), 0);
        check("mid_rst_pending", exp_dq.size(), 0);

        en0 = en_cnt;
        send_frame(vecs[0]);
        repeat (3) step(1'b0, 8'h00);
        check("post_rst_en", en_cnt - en0, 20);
        check("post_rst_frame_cnt", int'(frame_cnt), 1);
        check("post_rst_err_cnt", int'(err_cnt), 1);
        check("post_rst_pending", exp_dq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
